instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Streaming RISC-V RV32I instruction encoder; the inverse of the immediate decode path. Takes format, opcode, register, funct and 32-bit immediate fields over a valid/ready input and emits packed 32-bit instruction words over a valid/ready output. It range-checks immediates and expands the LI pseudo-instruction into one or two words (ADDI, or LUI+ADDI). Feeds the test program generator and the boot-ROM builder ahead of instruction memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
- in_fmt  in  4  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7–15 unsupported
- in_opcode  in  7  opcode[6:0] (ignored for LI)
- in_funct3  in  3  funct3 (R/I/S/B)
- in_funct7  in  7  funct7 (R only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate / LI constant
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range, misaligned, or in_fmt unsupported
- out_last  out  1  final word of this request

## Operation
- Field packing for all formats: opcode→[6:0], rd→[11:7], funct3→[14:12], rs1→[19:15], rs2→[24:20], funct7→[31:25].
- R: no immediate, err=0.
- I: [31:20]=imm[11:0]. err if imm ∉ [-2048, 2047].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range as I.
- B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. err if imm[0]=1 or imm ∉ [-4096, 4094].
- U: [31:12]=imm[31:12]. err if imm[11:0]≠0.
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. err if imm[0]=1 or imm ∉ [-2^20, 2^20-2].
- Fields unused by a format (rd for S/B, for example) are packed as given. On err, the word is still emitted with truncated fields and err=1.
- Unsupported fmt: emit 32'h00000013 (NOP) with err=1, last=1.
- LI, with lo=imm[11:0] and hi=(imm+0x800)[31:12], computed mod 2^32:
  - If imm ∈ [-2048, 2047]: one word, ADDI rd,x0,imm (opcode 0010011, funct3 000).
  - Else if lo=0: one word, LUI rd,hi (opcode 0110111).
  - Else: two words, LUI rd,hi then ADDI rd,rd,lo.
  - LI never sets err.
- FSM states:
  - IDLE: output empty.
  - HOLD: output holds a single or final word.
  - PEND: output holds the LUI word; the ADDI word is stored internally.
- FSM transitions:
  - IDLE→HOLD or PEND on accept.
  - HOLD→IDLE on pop with no new accept; HOLD→HOLD or PEND on pop with a simultaneous accept.
  - PEND→HOLD on pop, loading the ADDI word.
- in_ready = (state≠PEND) & (!out_valid | out_ready).

## Timing
- Reset (async): state IDLE. out_valid=0, out_instr=0, out_err=0, out_last=0. in_ready=1 once reset is released.
- Latency: request accepted at edge N appears on the outputs after edge N (registered, 1 cycle).
- Throughput: 1 word/cycle with out_ready held high. LI two-word: in_ready=0 for the cycle the LUI word is presented, and the ADDI word follows on the next pop.
- Backpressure: while out_valid & !out_ready, out_instr, out_err and out_last are held stable.
- Simultaneous pop and accept in HOLD: the new word replaces the old one at the same edge, with no bubble.
- Reset during PEND discards the pending ADDI word; nothing is emitted after reset.
- out_last=0 only on the LUI word of a two-word LI.

## Test plan
- I: opcode 0010011, funct3 0, rd 5, rs1 0, imm 0xFFFFFFFF → 0xFFF00293, err 0, last 1, one cycle after accept.
- B: opcode 1100011, funct3 0, rs1 1, rs2 2, imm -8 → 0xFE208CE3. Same with imm 3 → err 1. Same with imm 4096 → err 1.
- LI rd 10, imm 0x12345FFF → 0x12346537 (last 0), then 0xFFF50513 (last 1); in_ready 0 during the first word.
- LI edge cases:
  - rd 1, imm 5 → single word 0x00500093.
  - rd 1, imm 0x00001000 → single word 0x000010B7.
  - rd 1, imm 0x7FFFF800 → 0x800000B7, then 0x80008093.
- Streaming and backpressure: 4 back-to-back R requests with out_ready=1 → 4 words on 4 consecutive cycles. Then drop out_ready for 3 cycles → out_instr stable, in_ready 0.
- Reset in PEND: assert rst while the LUI word is presented → out_valid 0 immediately; after release, no ADDI word appears and in_ready=1.

Source files
------------

// File: rtl/instruction_encoder.sv
// Streaming RV32I instruction encoder: packs format/field requests into 32-bit words,
// range-checks immediates and expands LI into ADDI or LUI(+ADDI).
module instruction_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned UW   = 20;
  localparam logic [6:0]      OP_IMM = 7'b0010011;
  localparam logic [6:0]      OP_LUI = 7'b0110111;
  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, HOLD, PEND} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            err_q, err_d;
  logic            last_q, last_d;

  logic [XLEN-1:0] enc_instr;
  logic [XLEN-1:0] enc_addi;
  logic            enc_err;
  logic            enc_two;
  logic            fits12, fits13, fits21;
  logic [UW-1:0]   li_hi;
  logic            accept, pop;

  assign fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
  // (imm + 0x800) >> 12 without materialising the unused low sum bits
  assign li_hi  = in_imm[31:12] + UW'(in_imm[11]);

  // Combinational encode of the request currently on the input
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    enc_two   = 1'b0;
    enc_addi  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
    unique case (in_fmt)
      4'd0: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      4'd1: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = !fits12;
      end
      4'd2: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = !fits12;
      end
      4'd3: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = in_imm[0] || !fits13;
      end
      4'd4: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != '0);
      end
      4'd5: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = in_imm[0] || !fits21;
      end
      4'd6: begin
        enc_err = 1'b0;
        if (fits12) begin
          enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
        end else if (in_imm[11:0] == '0) begin
          enc_instr = {in_imm[31:12], in_rd, OP_LUI};
        end else begin
          enc_instr = {li_hi, in_rd, OP_LUI};
          enc_two   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;

  // Next-state and output-register logic
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pend_d   = pend_q;
    err_d    = err_q;
    last_d   = last_q;
    in_ready = (state_q != PEND) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    pop      = out_valid && out_ready;
    if (accept) begin
      instr_d = enc_instr;
      err_d   = enc_err;
      last_d  = !enc_two;
      state_d = enc_two ? PEND : HOLD;
      if (enc_two) pend_d = enc_addi;
    end else if (pop) begin
      if (state_q == PEND) begin
        instr_d = pend_q;
        err_d   = 1'b0;
        last_d  = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: expected words are queued at drive time
// and checked by a monitor as the encoder presents them.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_fmt;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err, out_last;
  logic [31:0] out_instr;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int cyc      = 0;
  int last_acc = 0;

  instruction_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every word the consumer takes must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", out_instr, e.instr);
        chk("err", 32'(out_err), 32'(e.err));
        chk("last", 32'(out_last), 32'(e.last));
        pops++;
      end
    end
  end

  function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic push(input logic [31:0] instr, input logic err, input logic last);
    exp_t e;
    e.instr = instr;
    e.err   = err;
    e.last  = last;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bit ok = 0;
    in_fmt = fmt; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    last_acc = cyc;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int base_pops, first_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // I-type, one-cycle latency
    push(32'hFFF0_0293, 1'b0, 1'b1);
    drive(4'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    idle();
    chk("i_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Branch range/alignment, S/U/J packing, I overflow, unsupported fmt
    push(32'hFE20_8CE3, 1'b0, 1'b1);
    drive(4'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    push(32'h0020_8163, 1'b1, 1'b1);
    drive(4'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    push(32'h8020_8063, 1'b1, 1'b1);
    drive(4'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    push(32'hFE51_2E23, 1'b0, 1'b1);
    drive(4'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
    push(32'h1234_51B7, 1'b0, 1'b1);
    drive(4'd4, 7'b0110111, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
    push(32'h0000_01B7, 1'b1, 1'b1);
    drive(4'd4, 7'b0110111, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0123);
    push(32'h0010_00EF, 1'b0, 1'b1);
    drive(4'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    push(32'h8000_0293, 1'b1, 1'b1);
    drive(4'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
    push(32'h0000_0013, 1'b1, 1'b1);
    drive(4'd9, 7'b0110011, 3'd1, 7'd1, 5'd7, 5'd7, 5'd7, 32'h1234_5678);
    idle();
    drain();

    // LI two-word: input blocked while LUI is presented
    push(32'h1234_6537, 1'b0, 1'b0);
    push(32'hFFF5_0513, 1'b0, 1'b1);
    drive(4'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    idle();
    chk("li_ready_low", 32'(in_ready), 32'd0);
    chk("li_lui_last", 32'(out_last), 32'd0);
    drain();

    // LI edge cases, back-to-back
    push(32'h0050_0093, 1'b0, 1'b1);
    drive(4'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    push(32'h0000_10B7, 1'b0, 1'b1);
    drive(4'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
    push(32'h8000_00B7, 1'b0, 1'b0);
    push(32'h8000_8093, 1'b0, 1'b1);
    drive(4'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h7FFF_F800);
    idle();
    drain();

    // Streaming R requests, then backpressure
    base_pops = pops;
    first_acc = 0;
    for (int k = 0; k < 4; k++) begin
      push(r_word(7'(k), 5'(k + 1), 5'(k + 2), 3'(k), 5'(k + 3)), 1'b0, 1'b1);
      drive(4'd0, 7'b0110011, 3'(k), 7'(k), 5'(k + 3), 5'(k + 2), 5'(k + 1), 32'd0);
      if (k == 0) first_acc = last_acc;
    end
    chk("stream_cycles", 32'(last_acc - first_acc), 32'd3);
    chk("stream_pops", 32'(pops - base_pops), 32'd3);
    push(r_word(7'h20, 5'd9, 5'd8, 3'd5, 5'd31), 1'b0, 1'b1);
    drive(4'd0, 7'b0110011, 3'd5, 7'h20, 5'd31, 5'd8, 5'd9, 32'd0);
    out_ready = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_instr", out_instr, r_word(7'h20, 5'd9, 5'd8, 3'd5, 5'd31));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset while LUI is presented drops the pending ADDI
    out_ready = 1'b0;
    drive(4'd6, 7'd0, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    idle();
    chk("pend_valid", 32'(out_valid), 32'd1);
    chk("pend_lui", out_instr, 32'h1234_6537);
    chk("pend_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("pend_rst_valid", 32'(out_valid), 32'd0);
    chk("pend_rst_instr", out_instr, 32'd0);
    chk("pend_rst_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
